// File: rtl/mu0_io_pkg.sv
// ---------------------------------------------------------------------------
// mu0_io_pkg
//   Shared definitions for the mu0 memory-mapped I/O port:
//     - register offsets inside the 16-word I/O window
//     - run/halt state encoding
//     - STATUS register bit positions and a helper that packs the STATUS word
//   Imported by mu0_io_fifo and mu0_io_port.
// ---------------------------------------------------------------------------
package mu0_io_pkg;

  // Word offsets inside the I/O window (offset = addr[3:0])
  localparam logic [3:0] OFF_MIN  = 4'd0;
  localparam logic [3:0] OFF_MAX  = 4'd1;
  localparam logic [3:0] OFF_STAT = 4'd2;
  localparam logic [3:0] OFF_OUT  = 4'd3;
  localparam logic [3:0] OFF_CYC  = 4'd4;
  localparam logic [3:0] OFF_CLR  = 4'd5;

  // Processor run/halt tracking
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } io_state_t;

  // STATUS register layout
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_HALT    = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_MSB = 8;

  function automatic logic [15:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic       halted,
    input logic [4:0] count
  );
    logic [15:0] s;
    s = '0;
    s[STAT_FULL]                      = full;
    s[STAT_EMPTY]                     = empty;
    s[STAT_OVF]                       = ovf;
    s[STAT_HALT]                      = halted;
    s[STAT_CNT_MSB:STAT_CNT_LSB]      = count;
    return s;
  endfunction

endpackage : mu0_io_pkg

// File: rtl/mu0_io_fifo.sv
// ---------------------------------------------------------------------------
// mu0_io_fifo
//   Small synchronous FIFO holding words written to the OUT register until
//   the downstream consumer takes them.  The head word is presented
//   combinationally so the consumer sees it in the cycle it becomes valid.
//
//   Parameters
//     WIDTH  word width
//     DEPTH  number of entries, power of 2 (2..16)
//
//   Ports
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset (empties the FIFO)
//     push   in   write din on this edge (accepted if not full, or if a pop
//                 frees a slot on the same edge)
//     din    in   word to write
//     full   out  DEPTH words stored
//     pop    in   remove the head on this edge (ignored when empty)
//     dout   out  head word, 0 when empty
//     empty  out  no words stored
//     count  out  number of stored words (0..DEPTH)
// ---------------------------------------------------------------------------
module mu0_io_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  logic do_pop;
  logic do_push;

  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // A pop on an empty FIFO would expose a stale slot, so it is dropped.
  // A push into a full FIFO only succeeds when a pop frees a slot this edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Holding 0 on the output when empty keeps out_data clean after reset
  // and after the last word drains.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

  // Storage carries no reset: contents are meaningless once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule : mu0_io_fifo

// File: rtl/mu0_io_port.sv
// ---------------------------------------------------------------------------
// mu0_io_port
//   Memory-mapped I/O unit sitting beside the mu0 program memory.  It snoops
//   the bus and claims the 16-word window [IO_BASE .. IO_BASE+15]:
//     +0 MIN   (RO)  min operand
//     +1 MAX   (RO)  max operand
//     +2 STATUS(RO)  [0] full [1] empty [2] overflow (sticky) [3] halted
//                    [8:4] FIFO word count
//     +3 OUT   (WO)  push a word into the output FIFO
//     +4 CYCLE (RO)  cycles spent running (low 16 bits)
//     +5 CLR   (WO)  any write clears the overflow flag
//     others read 0, writes ignored
//   Reads are combinational; writes take effect on the clock edge.
//
//   Optional feature macro: MU0_IO_CYCLE_CNT_EN
//     defined     - CYCLE counts clock edges while running, saturates at
//                   all-ones, freezes once halted, clears on reset
//     not defined - no counter; CYCLE reads 0
//
//   Parameters
//     IO_BASE     base of the I/O window (low 4 bits must be 0)
//     FIFO_DEPTH  output FIFO entries, power of 2, 2..16
//     CNT_W       cycle counter width
//
//   Ports
//     clk        in    system clock, rising edge
//     rst_n      in    asynchronous active-low reset
//     addr       in    mu0 address bus
//     data       inout mu0 data bus, driven only during I/O window reads
//     MEMrq      in    mu0 memory request
//     RnW        in    1 = read, 0 = write
//     STP_flag   in    mu0 has executed STP
//     min        in    operand shown at offset 0
//     max        in    operand shown at offset 1
//     mem_cs_n   out   0 = program memory may respond
//     out_data   out   FIFO head word
//     out_valid  out   FIFO non-empty
//     out_ready  in    consumer takes the head when out_valid & out_ready
// ---------------------------------------------------------------------------
module mu0_io_port
  import mu0_io_pkg::*;
#(
  parameter logic [11:0] IO_BASE    = 12'hFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  inout  wire  [15:0] data,
  input  logic        MEMrq,
  input  logic        RnW,
  input  logic        STP_flag,
  input  logic [15:0] min,
  input  logic [15:0] max,
  output logic        mem_cs_n,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic       hit;
  logic [3:0] offset;
  logic       wr_en;
  logic       push;
  logic       clr;

  assign hit    = MEMrq & (addr[11:4] == IO_BASE[11:4]);
  assign offset = addr[3:0];
  assign wr_en  = hit & ~RnW;
  assign push   = wr_en & (offset == OFF_OUT);
  assign clr    = wr_en & (offset == OFF_CLR);

  // Program memory is kept deselected while reset is held, and whenever
  // the I/O window owns the access.
  assign mem_cs_n = ~rst_n | hit;

  // ------------------------------------------------------------------
  // Output FIFO
  // ------------------------------------------------------------------
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;

  mu0_io_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (data),
    .full  (fifo_full),
    .pop   (out_ready),
    .dout  (out_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = ~fifo_empty;

  // ------------------------------------------------------------------
  // Sticky overflow: set only when a push is actually dropped.  A push
  // into a full FIFO while the consumer pops on the same edge is accepted.
  // ------------------------------------------------------------------
  logic overflow_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (clr) begin
      overflow_reg <= 1'b0;
    end else if (push & fifo_full & ~out_ready) begin
      overflow_reg <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Run/halt tracking.  The first bus request starts the processor; STP
  // halts it, and only reset leaves HALT.  If STP is already asserted on
  // the very first request the machine goes straight to HALT.
  // ------------------------------------------------------------------
  io_state_t state_reg;
  logic      halted_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MEMrq) begin
            if (STP_flag) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg  <= RUN;
            end
          end
        end
        RUN: begin
          if (STP_flag) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end
        end
        HALT: begin
          state_reg  <= HALT;
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg  <= IDLE;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Cycle counter (optional)
  // ------------------------------------------------------------------
  logic [15:0] cycle_word;

`ifdef MU0_IO_CYCLE_CNT_EN
  logic [CNT_W-1:0] cycle_reg;

  // Counts every edge seen while running, including the edge that moves
  // to HALT, then holds.  Stops at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg <= '0;
    end else if ((state_reg == RUN) && (cycle_reg != {CNT_W{1'b1}})) begin
      cycle_reg <= cycle_reg + CNT_W'(1);
    end
  end

  // Truncates to the low 16 bits or zero-extends narrower counters.
  assign cycle_word = 16'(cycle_reg);
`else
  assign cycle_word = 16'h0000;
`endif

  // ------------------------------------------------------------------
  // Read mux and bus driver
  // ------------------------------------------------------------------
  logic [15:0] status_word;
  logic [15:0] rd_word;

  assign status_word = pack_status(fifo_full, fifo_empty, overflow_reg,
                                   halted_reg, 5'(fifo_count));

  always_comb begin
    rd_word = 16'h0000;
    case (offset)
      OFF_MIN:  rd_word = min;
      OFF_MAX:  rd_word = max;
      OFF_STAT: rd_word = status_word;
      OFF_CYC:  rd_word = cycle_word;
      default:  rd_word = 16'h0000;
    endcase
  end

  // The bus is released whenever the access is not an I/O window read,
  // leaving the data lines to program memory or the processor.
  assign data = (hit & RnW) ? rd_word : 16'hzzzz;

endmodule : mu0_io_port

// File: tb/tb_mu0_io_port.sv
// ---------------------------------------------------------------------------
// tb_mu0_io_port
//   Directed scenarios followed by a randomized run, all checked against a
//   queue-based model of the I/O port kept in this file.
// ---------------------------------------------------------------------------
module tb_mu0_io_port;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] addr;
  wire  [15:0] data;
  logic        MEMrq;
  logic        RnW;
  logic        STP_flag;
  logic [15:0] min_v;
  logic [15:0] max_v;
  logic        mem_cs_n;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  // Bench-side bus driver: processor write data, or program memory answering
  logic        drv_en;
  logic [15:0] drv_val;
  assign data = drv_en ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  mu0_io_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .data      (data),
    .MEMrq     (MEMrq),
    .RnW       (RnW),
    .STP_flag  (STP_flag),
    .min       (min_v),
    .max       (max_v),
    .mem_cs_n  (mem_cs_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- reference model ----------------
  logic [15:0] mq[$];       // words waiting for the consumer
  bit          m_ovf;
  int          m_st;        // 0 not started, 1 running, 2 halted
  int unsigned m_cyc;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] exp_status();
    logic [15:0] s;
    s      = 16'h0000;
    s[0]   = (mq.size() == DEPTH);
    s[1]   = (mq.size() == 0);
    s[2]   = m_ovf;
    s[3]   = (m_st == 2);
    s[8:4] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic [15:0] exp_read(input logic [3:0] off);
    case (off)
      4'd0: return min_v;
      4'd1: return max_v;
      4'd2: return exp_status();
`ifdef MU0_IO_CYCLE_CNT_EN
      4'd4: return 16'(m_cyc);
`endif
      default: return 16'h0000;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit in_win, wr, pop;
    in_win = MEMrq && (addr[11:4] == 8'hFF);
    wr     = in_win && !RnW;
    pop    = out_ready && (mq.size() > 0);
    if (m_st == 1 && m_cyc < 32'd65535) m_cyc++;
    if (m_st == 0 && MEMrq)      m_st = STP_flag ? 2 : 1;
    else if (m_st == 1 && STP_flag) m_st = 2;
    if (pop) void'(mq.pop_front());
    if (wr && addr[3:0] == 4'd3) begin
      if (mq.size() < DEPTH) mq.push_back(drv_val);
      else                   m_ovf = 1'b1;
    end
    if (wr && addr[3:0] == 4'd5) m_ovf = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_st  = 0;
    m_cyc = 0;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    MEMrq  = 1'b0;
    RnW    = 1'b1;
    drv_en = 1'b0;
    addr   = 12'h000;
  endtask

  task automatic bus_read(input logic [3:0] off);
    addr   = {8'hFF, off};
    MEMrq  = 1'b1;
    RnW    = 1'b1;
    drv_en = 1'b0;
    #1;
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [15:0] val);
    addr    = {8'hFF, off};
    MEMrq   = 1'b1;
    RnW     = 1'b0;
    drv_en  = 1'b1;
    drv_val = val;
    step();
    bus_idle();
    #1;
  endtask

  task automatic chk_read(input string tag, input logic [3:0] off);
    bus_read(off);
    chk(tag, {16'h0, data}, {16'h0, exp_read(off)});
    chk({tag, "_cs"}, {31'h0, mem_cs_n}, 32'd1);
  endtask

  // Program memory answers a read with two patterns; the port must not disturb either.
  task automatic chk_released(input string tag);
    drv_en  = 1'b1;
    drv_val = 16'h0000;
    #1;
    chk({tag, "_lo"}, {16'h0, data}, 32'h0000);
    drv_val = 16'hFFFF;
    #1;
    chk({tag, "_hi"}, {16'h0, data}, 32'hFFFF);
    drv_en  = 1'b0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_valid"}, {31'h0, out_valid}, {31'h0, (mq.size() > 0)});
    if (mq.size() > 0) chk({tag, "_data"}, {16'h0, out_data}, {16'h0, mq[0]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_idle();
    out_ready = 1'b0;
    STP_flag  = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int          op;
    logic [3:0]  off;

    rst_n     = 1'b0;
    bus_idle();
    out_ready = 1'b0;
    STP_flag  = 1'b0;
    min_v     = 16'h0;
    max_v     = 16'h0;
    drv_val   = 16'h0;
    model_reset();

    // ---- reset state ----
    #3;
    chk("rst_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_data", {16'h0, out_data}, 32'd0);
    chk("rst_cs", {31'h0, mem_cs_n}, 32'd1);
    chk_released("rst_bus");
    bus_read(4'd2);
    chk("rst_status", {16'h0, data}, 32'h0002);
    bus_idle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("idle_cs", {31'h0, mem_cs_n}, 32'd0);

    // ---- 1: operand reads, outside-window access ----
    min_v = 16'd1;
    max_v = 16'd10;
    bus_read(4'd0);
    chk("t1_min", {16'h0, data}, 32'h0001);
    chk("t1_min_cs", {31'h0, mem_cs_n}, 32'd1);
    bus_read(4'd1);
    chk("t1_max", {16'h0, data}, 32'h000A);
    addr = 12'h010;
    #1;
    chk("t1_out_cs", {31'h0, mem_cs_n}, 32'd0);
    chk_released("t1_out_bus");
    step();
    bus_idle();

    // ---- 2: two words through the FIFO ----
    out_ready = 1'b0;
    bus_write(4'd3, 16'h1234);
    bus_write(4'd3, 16'h5678);
    chk("t2_valid", {31'h0, out_valid}, 32'd1);
    chk("t2_head0", {16'h0, out_data}, 32'h1234);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("t2_head1", {16'h0, out_data}, 32'h5678);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chk("t2_drained", {31'h0, out_valid}, 32'd0);

    // ---- 3: overflow, then clear ----
    for (int i = 0; i < 9; i++) bus_write(4'd3, 16'(16'hA000 + i));
    bus_read(4'd2);
    chk("t3_status_ovf", {16'h0, data}, 32'h0085);
    chk_read("t3_status_model", 4'd2);
    bus_write(4'd5, 16'h0000);
    bus_read(4'd2);
    chk("t3_status_clr", {16'h0, data}, 32'h0081);

    // ---- 4: push and pop on the same edge while full ----
    out_ready = 1'b1;
    bus_write(4'd3, 16'hBEEF);
    bus_read(4'd2);
    chk("t4_status", {16'h0, data}, 32'h0081);
    bus_idle();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_drain", {31'h0, out_valid}, 32'd1);
      chk_out("t4_order");
      step();
    end
    #1;
    chk("t4_empty", {31'h0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 2) == 0);
      min_v     = 16'($urandom);
      max_v     = 16'($urandom);
      op        = $urandom_range(0, 9);
      drv_en    = 1'b0;
      if (op <= 4) begin
        addr = 12'hFF3; MEMrq = 1'b1; RnW = 1'b0;
        drv_en = 1'b1; drv_val = 16'($urandom);
      end else if (op == 5) begin
        addr = {8'hFF, 4'($urandom_range(0, 15))}; MEMrq = 1'b1; RnW = 1'b0;
        drv_en = 1'b1; drv_val = 16'($urandom);
      end else if (op <= 8) begin
        off  = 4'($urandom_range(0, 15));
        addr = {8'hFF, off}; MEMrq = 1'b1; RnW = 1'b1;
      end else begin
        addr = 12'($urandom); MEMrq = 1'($urandom); RnW = 1'b1;
      end
      #1;
      chk_out("rnd_out");
      chk("rnd_cs", {31'h0, mem_cs_n}, {31'h0, (MEMrq && addr[11:4] == 8'hFF)});
      if (op >= 6 && op <= 8) chk("rnd_read", {16'h0, data}, {16'h0, exp_read(addr[3:0])});
      step();
    end
    bus_idle();
    out_ready = 1'b0;

    // ---- 6: reset in the middle of a burst ----
    do_reset();
    for (int i = 0; i < 3; i++) bus_write(4'd3, 16'(16'h0C00 + i));
    #2;
    chk("t6_pre_valid", {31'h0, out_valid}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", {31'h0, out_valid}, 32'd0);
    chk("t6_out_data", {16'h0, out_data}, 32'd0);
    bus_read(4'd2);
    chk("t6_status", {16'h0, data}, 32'h0002);
    bus_idle();
    #1;
    chk("t6_cs", {31'h0, mem_cs_n}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // ---- 5: cycle counter and halt ----
    chk_read("t5_cyc_start", 4'd4);
    step();
    bus_idle();
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) STP_flag = 1'b1;
      step();
    end
    bus_read(4'd4);
`ifdef MU0_IO_CYCLE_CNT_EN
    chk("t5_cyc", {16'h0, data}, 32'd20);
`else
    chk("t5_cyc", {16'h0, data}, 32'd0);
`endif
    chk_read("t5_cyc_model", 4'd4);
    bus_read(4'd2);
    chk("t5_halted", {31'h0, data[3]}, 32'd1);
    bus_idle();
    for (int k = 0; k < 5; k++) step();
    bus_read(4'd4);
`ifdef MU0_IO_CYCLE_CNT_EN
    chk("t5_cyc_frozen", {16'h0, data}, 32'd20);
`else
    chk("t5_cyc_frozen", {16'h0, data}, 32'd0);
`endif
    // Still serving I/O while halted
    bus_write(4'd3, 16'h4242);
    chk_out("t5_halt_push");
    bus_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mu0_io_port
